// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared sequencer/core definitions
package seq_pkg;

    localparam int INSTR_W = 18;
    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Core instruction field positions
    localparam int F_SAVE      = 17;
    localparam int F_WRITE     = 16;
    localparam int F_ADDR_HI   = 15;
    localparam int F_ADDR_LO   = 8;
    localparam int F_IN_SEL_HI = 7;
    localparam int F_IN_SEL_LO = 6;
    localparam int F_OUT_SEL   = 5;
    localparam int F_OUT_EN    = 4;
    localparam int F_ALU_HI    = 3;
    localparam int F_ALU_LO    = 0;

endpackage

// File: rtl/seq_prog_ram.sv
// rtl/seq_prog_ram.sv - microprogram store, sync write / async read
module seq_prog_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - microprogram sequencer with one hardware loop
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = seq_pkg::INSTR_W,
    parameter int LOOP_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               prog_we_i,
    input  logic [ADDR_W-1:0]  prog_addr_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    input  logic [ADDR_W:0]    prog_len_i,
    input  logic [ADDR_W-1:0]  loop_start_i,
    input  logic [ADDR_W-1:0]  loop_end_i,
    input  logic [LOOP_W-1:0]  loop_count_i,
    input  logic               start_i,
    input  logic               hold_i,
    input  logic               abort_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [LOOP_W-1:0]  pass_o
);

    import seq_pkg::*;

    seq_state_e state_q, state_d;

    logic [ADDR_W:0]    len_q;
    logic [ADDR_W-1:0]  ls_q, le_q, pc_q;
    logic [LOOP_W-1:0]  cnt_q, pass_q;
    logic [INSTR_W-1:0] instr_q, rd_data;
    logic               valid_q, done_q, done_pend_q;

    logic loop_en, at_loop_end, more_passes, loop_back, last_word;
    logic accept_start, issue, finish, mem_we;

    seq_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (mem_we),
        .waddr (prog_addr_i),
        .wdata (prog_data_i),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    // Loop only honoured when the body lies wholly inside the program
    assign loop_en     = (ls_q <= le_q) && ({1'b0, le_q} < len_q);
    assign at_loop_end = loop_en && (pc_q == le_q);
    assign more_passes = ({1'b0, pass_q} + (LOOP_W+1)'(1)) < {1'b0, cnt_q};
    assign loop_back   = at_loop_end && more_passes;
    assign last_word   = !loop_back && ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && (prog_len_i != '0)) state_d = RUN;
            RUN:     if (abort_i || (!hold_i && last_word)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        accept_start = 1'b0;
        issue        = 1'b0;
        finish       = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                accept_start = start_i;
                mem_we       = prog_we_i;
            end
            RUN: begin
                busy_o = 1'b1;
                if (!abort_i && !hold_i) begin
                    issue  = 1'b1;
                    finish = last_word;
                end
            end
            default: ;
        endcase
    end

    // done is delayed one extra cycle so it never overlaps the last word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= '0;
            pass_q      <= '0;
            len_q       <= '0;
            ls_q        <= '0;
            le_q        <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            instr_q     <= issue ? rd_data : INSTR_W'(NOP);
            valid_q     <= issue;
            done_q      <= done_pend_q;
            done_pend_q <= finish || (accept_start && (prog_len_i == '0));
            if (accept_start) begin
                len_q  <= prog_len_i;
                ls_q   <= loop_start_i;
                le_q   <= loop_end_i;
                cnt_q  <= (loop_count_i == '0) ? LOOP_W'(1) : loop_count_i;
                pc_q   <= '0;
                pass_q <= '0;
            end else if (issue) begin
                if (at_loop_end && (pass_q != '1)) begin
                    pass_q <= pass_q + LOOP_W'(1);
                end
                pc_q <= loop_back ? ls_q : pc_q + ADDR_W'(1);
            end
        end
    end

    assign instruction_o = instr_q;
    assign valid_o       = valid_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 18;
    localparam int LOOP_W  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic [ADDR_W:0]    prog_len = '0;
    logic [ADDR_W-1:0]  loop_start = '0;
    logic [ADDR_W-1:0]  loop_end = '0;
    logic [LOOP_W-1:0]  loop_count = '0;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic               abort = 1'b0;
    logic [INSTR_W-1:0] instruction;
    logic               valid, busy, done;
    logic [LOOP_W-1:0]  pass_cnt;

    int total = 0;
    int bad = 0;

    logic [INSTR_W-1:0] tb_mem [2**ADDR_W];
    logic [INSTR_W-1:0] exp_q [$];
    int                 exp_pass;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .prog_we_i     (prog_we),
        .prog_addr_i   (prog_addr),
        .prog_data_i   (prog_data),
        .prog_len_i    (prog_len),
        .loop_start_i  (loop_start),
        .loop_end_i    (loop_end),
        .loop_count_i  (loop_count),
        .start_i       (start),
        .hold_i        (hold),
        .abort_i       (abort),
        .instruction_o (instruction),
        .valid_o       (valid),
        .busy_o        (busy),
        .done_o        (done),
        .pass_o        (pass_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_word(input int addr, input logic [INSTR_W-1:0] data);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
        tb_mem[addr] = data;
    endtask

    // Program order: prefix, body repeated N times, tail
    task automatic build_expected(input int len, input int ls, input int le, input int cnt);
        int  n;
        bit  en;
        n  = (cnt == 0) ? 1 : cnt;
        en = (ls <= le) && (le < len);
        exp_q.delete();
        if (!en) begin
            for (int a = 0; a < len; a++) exp_q.push_back(tb_mem[a]);
        end else begin
            for (int a = 0; a <= le; a++) exp_q.push_back(tb_mem[a]);
            for (int p = 1; p < n; p++)
                for (int a = ls; a <= le; a++) exp_q.push_back(tb_mem[a]);
            for (int a = le + 1; a < len; a++) exp_q.push_back(tb_mem[a]);
        end
        exp_pass = en ? n : 0;
    endtask

    // cut_kind: 0 none, 1 abort, 2 async reset, applied once cut_at words were seen
    task automatic run_prog(input int len, input int ls, input int le, input int cnt,
                            input int hold_after, input int hold_len, input bit rand_hold,
                            input int cut_at, input int cut_kind, input bit we_in_run);
        int idx;
        int hleft;
        bit h;
        idx   = 0;
        hleft = hold_len;
        build_expected(len, ls, le, cnt);
        prog_len   = (ADDR_W+1)'(len);
        loop_start = ADDR_W'(ls);
        loop_end   = ADDR_W'(le);
        loop_count = LOOP_W'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (len == 0) begin
            chk("nul_valid", 32'(valid), 0);
            chk("nul_busy", 32'(busy), 0);
            chk("nul_done_early", 32'(done), 0);
            @(negedge clk);
            chk("nul_done", 32'(done), 1);
            chk("nul_valid2", 32'(valid), 0);
            return;
        end
        chk("e0_valid", 32'(valid), 0);
        chk("e0_busy", 32'(busy), 1);
        if (we_in_run) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = ~tb_mem[0];
        end
        while (idx < exp_q.size()) begin
            if (idx == cut_at && cut_kind == 1) begin
                hold  = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                hold    = 1'b0;
                prog_we = 1'b0;
                chk("abort_valid", 32'(valid), 0);
                chk("abort_instr", 32'(instruction), 0);
                chk("abort_busy", 32'(busy), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 0);
                end
                return;
            end
            if (idx == cut_at && cut_kind == 2) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_instr", 32'(instruction), 0);
                chk("rst_valid", 32'(valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_pass", 32'(pass_cnt), 0);
                @(negedge clk);
                rst_n   = 1'b1;
                prog_we = 1'b0;
                return;
            end
            h = 1'b0;
            if (idx == hold_after && hleft > 0) begin
                h = 1'b1;
                hleft--;
            end else if (rand_hold && $urandom_range(0, 3) == 0) begin
                h = 1'b1;
            end
            hold = h;
            @(negedge clk);
            prog_we = 1'b0;
            if (h) begin
                chk("hold_valid", 32'(valid), 0);
                chk("hold_instr", 32'(instruction), 0);
            end else begin
                chk("word_valid", 32'(valid), 1);
                chk($sformatf("word%0d", idx), 32'(instruction), 32'(exp_q[idx]));
                idx++;
            end
            chk("run_done_low", 32'(done), 0);
        end
        hold = 1'b0;
        @(negedge clk);
        chk("end_done", 32'(done), 1);
        chk("end_valid", 32'(valid), 0);
        chk("end_instr", 32'(instruction), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_pass", 32'(pass_cnt), 32'(exp_pass));
    endtask

    task automatic idle_tail();
        @(negedge clk);
        chk("tail_done", 32'(done), 0);
        chk("tail_valid", 32'(valid), 0);
    endtask

    initial begin
        #3;
        chk("reset_instr", 32'(instruction), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_pass", 32'(pass_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2**ADDR_W; i++)
            load_word(i, (i < 6) ? INSTR_W'(i) : INSTR_W'($urandom));

        // straight-through, loop disabled by start > end
        run_prog(5, 3, 1, 2, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();
        // loop 2..3, three passes
        run_prog(6, 2, 3, 3, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();
        // two stall cycles after the 4th word
        run_prog(6, 2, 3, 3, 4, 2, 1'b0, -1, 0, 1'b0);
        idle_tail();
        // abort on the 3rd word with a write attempted during the run
        run_prog(6, 2, 3, 3, -1, 0, 1'b0, 3, 1, 1'b1);
        run_prog(5, 3, 1, 2, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();
        // empty program, then loop_count of zero
        run_prog(0, 0, 0, 1, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();
        run_prog(6, 2, 3, 0, -1, 0, 1'b0, -1, 0, 1'b0);
        // back-to-back: start while done is high
        run_prog(6, 2, 3, 2, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();
        // full-depth program with the loop ending on the last address
        run_prog(2**ADDR_W, 250, 2**ADDR_W - 1, 2, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();

        for (int it = 0; it < 10; it++) begin
            int len, ls, le, cnt;
            for (int k = 0; k < 4; k++)
                load_word($urandom_range(0, 39), INSTR_W'($urandom));
            len = $urandom_range(1, 40);
            ls  = $urandom_range(0, 20);
            le  = $urandom_range(0, 30);
            cnt = $urandom_range(0, 4);
            run_prog(len, ls, le, cnt, -1, 0, 1'b1, -1, 0, 1'b0);
            idle_tail();
        end

        // async reset mid-loop, then replay from pc 0 with memory intact
        run_prog(6, 2, 3, 3, -1, 0, 1'b0, 5, 2, 1'b0);
        @(negedge clk);
        run_prog(6, 2, 3, 3, -1, 0, 1'b0, -1, 0, 1'b0);
        idle_tail();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
